// File: rtl/msftdvip_axi_sub_arb.sv
// msftdvip_axi_sub_arb
// Per-subordinate manager arbiter. Round-robin arbitrates the AW and AR
// address phases of NUM_MGRS managers onto one subordinate phase port, keeps
// W routing locked to the AW winner until its wlast, and fans the B/R
// responses (one-hot valid per manager) back out.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   *phase_mgr_i / *_valid_mgr_i      per-manager AW/W/AR bundles, manager m at
//   *_ready_mgr_o                     slice [m*LEN +: LEN]
//   awphase_o/_valid_o/_ready_i       AW to the subordinate stage
//   wphase_o/_valid_o/_ready_i        W to the subordinate stage
//   arphase_o/_valid_o/_ready_i       AR to the subordinate stage
//   bphase_i/_valid_i/_ready_o        B from the subordinate stage (valid one-hot)
//   bphase_mgr_o/_valid_mgr_o/_ready_mgr_i  B to managers
//   rphase_i/_valid_i/_ready_o        R from the subordinate stage (valid one-hot)
//   rphase_mgr_o/_valid_mgr_o/_ready_mgr_i  R to managers
//   aw_grant_o, ar_grant_o            one-hot current write owner / read grantee
module msftdvip_axi_sub_arb #(
  parameter int NUM_MGRS   = 2,
  parameter int APHASE_LEN = 100,
  parameter int WPHASE_LEN = 50,
  parameter int BPHASE_LEN = 10,
  parameter int RPHASE_LEN = 50,
  parameter int WLAST_POS  = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_MGRS*APHASE_LEN-1:0] awphase_mgr_i,
  input  logic [NUM_MGRS-1:0]            awphase_valid_mgr_i,
  output logic [NUM_MGRS-1:0]            awphase_ready_mgr_o,
  input  logic [NUM_MGRS*WPHASE_LEN-1:0] wphase_mgr_i,
  input  logic [NUM_MGRS-1:0]            wphase_valid_mgr_i,
  output logic [NUM_MGRS-1:0]            wphase_ready_mgr_o,
  input  logic [NUM_MGRS*APHASE_LEN-1:0] arphase_mgr_i,
  input  logic [NUM_MGRS-1:0]            arphase_valid_mgr_i,
  output logic [NUM_MGRS-1:0]            arphase_ready_mgr_o,
  output logic [APHASE_LEN-1:0]          awphase_o,
  output logic                           awphase_valid_o,
  input  logic                           awphase_ready_i,
  output logic [WPHASE_LEN-1:0]          wphase_o,
  output logic                           wphase_valid_o,
  input  logic                           wphase_ready_i,
  output logic [APHASE_LEN-1:0]          arphase_o,
  output logic                           arphase_valid_o,
  input  logic                           arphase_ready_i,
  input  logic [BPHASE_LEN-1:0]          bphase_i,
  input  logic [NUM_MGRS-1:0]            bphase_valid_i,
  output logic                           bphase_ready_o,
  output logic [BPHASE_LEN-1:0]          bphase_mgr_o,
  output logic [NUM_MGRS-1:0]            bphase_valid_mgr_o,
  input  logic [NUM_MGRS-1:0]            bphase_ready_mgr_i,
  input  logic [RPHASE_LEN-1:0]          rphase_i,
  input  logic [NUM_MGRS-1:0]            rphase_valid_i,
  output logic                           rphase_ready_o,
  output logic [RPHASE_LEN-1:0]          rphase_mgr_o,
  output logic [NUM_MGRS-1:0]            rphase_valid_mgr_o,
  input  logic [NUM_MGRS-1:0]            rphase_ready_mgr_i,
  output logic [NUM_MGRS-1:0]            aw_grant_o,
  output logic [NUM_MGRS-1:0]            ar_grant_o
);

  localparam int IDX_W = (NUM_MGRS > 1) ? $clog2(NUM_MGRS) : 1;
  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST_RST = idx_t'(NUM_MGRS - 1);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2} w_state_e;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_ADDR = 1'b1} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  idx_t     aw_grant_q, aw_grant_d, aw_last_q, aw_last_d;
  idx_t     ar_grant_q, ar_grant_d, ar_last_q, ar_last_d;
  logic     w_done_q, w_done_d;
  logic     aw_hs_s, wlast_hs_s, ar_hs_s;

  // Round-robin: scan from last+1 (wrapping) and take the first requester.
  function automatic idx_t rr_pick(input logic [NUM_MGRS-1:0] req, input idx_t last);
    idx_t win;
    logic found;
    int   cand;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_MGRS; k++) begin
      cand = (int'(last) + k) % NUM_MGRS;
      if (!found && req[cand]) begin
        win   = idx_t'(cand);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  function automatic logic [NUM_MGRS-1:0] onehot(input idx_t idx);
    return {{(NUM_MGRS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // State and arbitration pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      aw_grant_q <= '0;
      ar_grant_q <= '0;
      aw_last_q  <= LAST_RST;
      ar_last_q  <= LAST_RST;
      w_done_q   <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      aw_grant_q <= aw_grant_d;
      ar_grant_q <= ar_grant_d;
      aw_last_q  <= aw_last_d;
      ar_last_q  <= ar_last_d;
      w_done_q   <= w_done_d;
    end
  end

  // Write FSM: AW arbitration, AW/W steering to the owner, wlast tracking.
  always_comb begin
    w_state_d           = w_state_q;
    aw_grant_d          = aw_grant_q;
    aw_last_d           = aw_last_q;
    w_done_d            = w_done_q;
    awphase_o           = '0;
    awphase_valid_o     = 1'b0;
    awphase_ready_mgr_o = '0;
    wphase_o            = '0;
    wphase_valid_o      = 1'b0;
    wphase_ready_mgr_o  = '0;
    aw_hs_s             = 1'b0;
    wlast_hs_s          = 1'b0;

    // W stays routed to the owner from the AW grant until its wlast, so a
    // manager may send data ahead of its address handshake.
    if (w_state_q != W_IDLE) begin
      wphase_o                       = wphase_mgr_i[aw_grant_q*WPHASE_LEN +: WPHASE_LEN];
      wphase_valid_o                 = wphase_valid_mgr_i[aw_grant_q];
      wphase_ready_mgr_o[aw_grant_q] = wphase_ready_i;
      wlast_hs_s = wphase_valid_mgr_i[aw_grant_q] & wphase_ready_i &
                   wphase_mgr_i[aw_grant_q*WPHASE_LEN + WLAST_POS];
    end else begin
      wlast_hs_s = 1'b0;
    end

    case (w_state_q)
      W_IDLE: begin
        if (|awphase_valid_mgr_i) begin
          aw_grant_d = rr_pick(awphase_valid_mgr_i, aw_last_q);
          aw_last_d  = aw_grant_d;
          w_done_d   = 1'b0;
          w_state_d  = W_ADDR;
        end else begin
          w_state_d  = W_IDLE;
        end
      end
      W_ADDR: begin
        awphase_o                       = awphase_mgr_i[aw_grant_q*APHASE_LEN +: APHASE_LEN];
        awphase_valid_o                 = awphase_valid_mgr_i[aw_grant_q];
        awphase_ready_mgr_o[aw_grant_q] = awphase_ready_i;
        aw_hs_s = awphase_valid_mgr_i[aw_grant_q] & awphase_ready_i;
        if (aw_hs_s) begin
          // Burst already finished (earlier or this cycle): write is complete.
          if (w_done_q || wlast_hs_s) begin
            w_state_d = W_IDLE;
            w_done_d  = 1'b0;
          end else begin
            w_state_d = W_DATA;
          end
        end else if (wlast_hs_s) begin
          w_done_d = 1'b1;
        end else begin
          w_state_d = W_ADDR;
        end
      end
      W_DATA: begin
        if (wlast_hs_s) begin
          w_state_d = W_IDLE;
          w_done_d  = 1'b0;
        end else begin
          w_state_d = W_DATA;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        w_done_d  = 1'b0;
      end
    endcase
  end

  // Read FSM: AR arbitration and steering, one grant per handshake.
  always_comb begin
    r_state_d           = r_state_q;
    ar_grant_d          = ar_grant_q;
    ar_last_d           = ar_last_q;
    arphase_o           = '0;
    arphase_valid_o     = 1'b0;
    arphase_ready_mgr_o = '0;
    ar_hs_s             = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (|arphase_valid_mgr_i) begin
          ar_grant_d = rr_pick(arphase_valid_mgr_i, ar_last_q);
          ar_last_d  = ar_grant_d;
          r_state_d  = R_ADDR;
        end else begin
          r_state_d  = R_IDLE;
        end
      end
      R_ADDR: begin
        arphase_o                       = arphase_mgr_i[ar_grant_q*APHASE_LEN +: APHASE_LEN];
        arphase_valid_o                 = arphase_valid_mgr_i[ar_grant_q];
        arphase_ready_mgr_o[ar_grant_q] = arphase_ready_i;
        ar_hs_s = arphase_valid_mgr_i[ar_grant_q] & arphase_ready_i;
        if (ar_hs_s) begin
          r_state_d = R_IDLE;
        end else begin
          r_state_d = R_ADDR;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign aw_grant_o = (w_state_q != W_IDLE) ? onehot(aw_grant_q) : '0;
  assign ar_grant_o = (r_state_q != R_IDLE) ? onehot(ar_grant_q) : '0;

  // Responses carry their destination as a one-hot valid; no storage needed.
  assign bphase_mgr_o       = bphase_i;
  assign bphase_valid_mgr_o = bphase_valid_i;
  assign bphase_ready_o     = |(bphase_valid_i & bphase_ready_mgr_i);
  assign rphase_mgr_o       = rphase_i;
  assign rphase_valid_mgr_o = rphase_valid_i;
  assign rphase_ready_o     = |(rphase_valid_i & rphase_ready_mgr_i);

endmodule

// File: tb/tb_msftdvip_axi_sub_arb.sv
module tb_msftdvip_axi_sub_arb;
  localparam int NM = 2;
  localparam int AL = 100;
  localparam int WL = 50;
  localparam int BL = 10;
  localparam int RL = 50;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [NM*AL-1:0] awphase_mgr_i, arphase_mgr_i;
  logic [NM*WL-1:0] wphase_mgr_i;
  logic [NM-1:0]    awphase_valid_mgr_i, awphase_ready_mgr_o;
  logic [NM-1:0]    wphase_valid_mgr_i, wphase_ready_mgr_o;
  logic [NM-1:0]    arphase_valid_mgr_i, arphase_ready_mgr_o;
  logic [AL-1:0]    awphase_o, arphase_o;
  logic             awphase_valid_o, awphase_ready_i;
  logic [WL-1:0]    wphase_o;
  logic             wphase_valid_o, wphase_ready_i;
  logic             arphase_valid_o, arphase_ready_i;
  logic [BL-1:0]    bphase_i, bphase_mgr_o;
  logic [NM-1:0]    bphase_valid_i, bphase_valid_mgr_o, bphase_ready_mgr_i;
  logic             bphase_ready_o;
  logic [RL-1:0]    rphase_i, rphase_mgr_o;
  logic [NM-1:0]    rphase_valid_i, rphase_valid_mgr_o, rphase_ready_mgr_i;
  logic             rphase_ready_o;
  logic [NM-1:0]    aw_grant_o, ar_grant_o;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk_i = ~clk_i;

  msftdvip_axi_sub_arb #(
    .NUM_MGRS(NM), .APHASE_LEN(AL), .WPHASE_LEN(WL),
    .BPHASE_LEN(BL), .RPHASE_LEN(RL), .WLAST_POS(0)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .awphase_mgr_i(awphase_mgr_i), .awphase_valid_mgr_i(awphase_valid_mgr_i),
    .awphase_ready_mgr_o(awphase_ready_mgr_o),
    .wphase_mgr_i(wphase_mgr_i), .wphase_valid_mgr_i(wphase_valid_mgr_i),
    .wphase_ready_mgr_o(wphase_ready_mgr_o),
    .arphase_mgr_i(arphase_mgr_i), .arphase_valid_mgr_i(arphase_valid_mgr_i),
    .arphase_ready_mgr_o(arphase_ready_mgr_o),
    .awphase_o(awphase_o), .awphase_valid_o(awphase_valid_o), .awphase_ready_i(awphase_ready_i),
    .wphase_o(wphase_o), .wphase_valid_o(wphase_valid_o), .wphase_ready_i(wphase_ready_i),
    .arphase_o(arphase_o), .arphase_valid_o(arphase_valid_o), .arphase_ready_i(arphase_ready_i),
    .bphase_i(bphase_i), .bphase_valid_i(bphase_valid_i), .bphase_ready_o(bphase_ready_o),
    .bphase_mgr_o(bphase_mgr_o), .bphase_valid_mgr_o(bphase_valid_mgr_o),
    .bphase_ready_mgr_i(bphase_ready_mgr_i),
    .rphase_i(rphase_i), .rphase_valid_i(rphase_valid_i), .rphase_ready_o(rphase_ready_o),
    .rphase_mgr_o(rphase_mgr_o), .rphase_valid_mgr_o(rphase_valid_mgr_o),
    .rphase_ready_mgr_i(rphase_ready_mgr_i),
    .aw_grant_o(aw_grant_o), .ar_grant_o(ar_grant_o)
  );

  typedef struct {
    logic [NM-1:0] bv;
    logic [NM-1:0] brm;
    logic [BL-1:0] bd;
    logic [NM-1:0] rv;
    logic [NM-1:0] rrm;
    logic [RL-1:0] rd;
    logic          exp_bready;
    logic          exp_rready;
  } rsp_vec_t;

  rsp_vec_t tbl[8];
  int       rdy_pat[5];
  int       beat;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    awphase_mgr_i = '0; arphase_mgr_i = '0; wphase_mgr_i = '0;
    awphase_valid_mgr_i = '0; wphase_valid_mgr_i = '0; arphase_valid_mgr_i = '0;
    awphase_ready_i = 1'b0; wphase_ready_i = 1'b0; arphase_ready_i = 1'b0;
    bphase_i = '0; bphase_valid_i = '0; bphase_ready_mgr_i = '0;
    rphase_i = '0; rphase_valid_i = '0; rphase_ready_mgr_i = '0;
    awphase_mgr_i[0 +: AL]  = 100'hA0A0;
    awphase_mgr_i[AL +: AL] = 100'hA1A1;
    arphase_mgr_i[0 +: AL]  = 100'hB0B0;
    arphase_mgr_i[AL +: AL] = 100'hB1B1;

    // Response table: one-hot valid routing and merged ready.
    tbl[0] = '{2'b00, 2'b11, 10'h3A5, 2'b00, 2'b11, 50'h0,    1'b0, 1'b0};
    tbl[1] = '{2'b10, 2'b01, 10'h155, 2'b00, 2'b00, 50'h0,    1'b0, 1'b0};
    tbl[2] = '{2'b10, 2'b10, 10'h2AA, 2'b00, 2'b00, 50'h0,    1'b1, 1'b0};
    tbl[3] = '{2'b01, 2'b01, 10'h0F0, 2'b00, 2'b00, 50'h0,    1'b1, 1'b0};
    tbl[4] = '{2'b00, 2'b00, 10'h000, 2'b10, 2'b10, 50'h1111, 1'b0, 1'b1};
    tbl[5] = '{2'b00, 2'b00, 10'h000, 2'b10, 2'b01, 50'h2222, 1'b0, 1'b0};
    tbl[6] = '{2'b00, 2'b00, 10'h000, 2'b10, 2'b11, 50'h2222, 1'b0, 1'b1};
    tbl[7] = '{2'b11, 2'b10, 10'h001, 2'b01, 2'b10, 50'h3333, 1'b1, 1'b0};
    rdy_pat = '{1, 0, 1, 1, 1};

    // Reset state: no requests, readies high, nothing may be granted.
    tick(); tick();
    rst_i = 1'b0;
    wphase_valid_mgr_i = 2'b11; wphase_ready_i = 1'b1;
    awphase_ready_i = 1'b1; arphase_ready_i = 1'b1;
    #1;
    chk("rst_aw_grant", aw_grant_o, 2'b00);
    chk("rst_ar_grant", ar_grant_o, 2'b00);
    chk("rst_awvalid", awphase_valid_o, 1'b0);
    chk("rst_wvalid", wphase_valid_o, 1'b0);
    chk("rst_wready_mgr", wphase_ready_mgr_o, 2'b00);
    chk("rst_awready_mgr", awphase_ready_mgr_o, 2'b00);
    chk("rst_arready_mgr", arphase_ready_mgr_o, 2'b00);
    wphase_valid_mgr_i = '0; wphase_ready_i = 1'b0;
    awphase_ready_i = 1'b0; arphase_ready_i = 1'b0;

    // Response vectors.
    for (int i = 0; i < 8; i++) begin
      bphase_valid_i = tbl[i].bv; bphase_ready_mgr_i = tbl[i].brm; bphase_i = tbl[i].bd;
      rphase_valid_i = tbl[i].rv; rphase_ready_mgr_i = tbl[i].rrm; rphase_i = tbl[i].rd;
      #1;
      chk($sformatf("bready[%0d]", i), bphase_ready_o, tbl[i].exp_bready);
      chk($sformatf("rready[%0d]", i), rphase_ready_o, tbl[i].exp_rready);
      chk($sformatf("bvalid_mgr[%0d]", i), bphase_valid_mgr_o, tbl[i].bv);
      chk($sformatf("rvalid_mgr[%0d]", i), rphase_valid_mgr_o, tbl[i].rv);
      chk($sformatf("bdata[%0d]", i), bphase_mgr_o, tbl[i].bd);
      chk($sformatf("rdata[%0d]", i), rphase_mgr_o, tbl[i].rd);
    end
    bphase_valid_i = '0; bphase_ready_mgr_i = '0; rphase_valid_i = '0; rphase_ready_mgr_i = '0;

    // Both managers request AW together: mgr0 first, one cycle later.
    tick();
    awphase_valid_mgr_i = 2'b11;
    #1;
    chk("aw_latency_valid", awphase_valid_o, 1'b0);
    tick();
    chk("aw_first_grant", aw_grant_o, 2'b01);
    chk("aw_first_valid", awphase_valid_o, 1'b1);
    chk("aw_first_data", awphase_o, 100'hA0A0);
    chk("aw_ready_held", awphase_ready_mgr_o, 2'b00);
    wphase_valid_mgr_i = 2'b10; wphase_ready_i = 1'b1;
    wphase_mgr_i[WL +: WL] = {49'h0BAD, 1'b0};
    #1;
    chk("w_steer_owner", wphase_ready_mgr_o, 2'b01);
    chk("w_valid_owner_idle", wphase_valid_o, 1'b0);
    awphase_ready_i = 1'b1;
    #1;
    chk("aw_ready_steer", awphase_ready_mgr_o, 2'b01);
    tick();
    awphase_valid_mgr_i = 2'b10; awphase_ready_i = 1'b0;

    // mgr0 4-beat burst with ready 1,0,1,1,1 while mgr1 W stalls.
    beat = 0;
    for (int c = 0; c < 5; c++) begin
      wphase_valid_mgr_i = 2'b11;
      wphase_mgr_i[0 +: WL] = {49'h1000 + 49'(beat), (beat == 3)};
      wphase_ready_i = rdy_pat[c][0];
      #1;
      chk($sformatf("burst_mgr1_stall[%0d]", c), wphase_ready_mgr_o[1], 1'b0);
      chk($sformatf("burst_valid[%0d]", c), wphase_valid_o, 1'b1);
      chk($sformatf("burst_data[%0d]", c), wphase_o, {49'h1000 + 49'(beat), (beat == 3)});
      chk($sformatf("burst_owner[%0d]", c), aw_grant_o, 2'b01);
      tick();
      if (rdy_pat[c] != 0) beat++;
    end
    wphase_valid_mgr_i = '0; wphase_ready_i = 1'b0;
    chk("burst_idle", aw_grant_o, 2'b00);
    awphase_valid_mgr_i = 2'b11;
    tick();
    chk("rr_second_grant", aw_grant_o, 2'b10);
    chk("rr_second_data", awphase_o, 100'hA1A1);

    // mgr1: AW handshake and wlast in the same cycle -> straight to idle.
    awphase_ready_i = 1'b1; wphase_ready_i = 1'b1; wphase_valid_mgr_i = 2'b10;
    wphase_mgr_i[WL +: WL] = {49'h2000, 1'b1};
    #1;
    chk("same_cycle_awready", awphase_ready_mgr_o, 2'b10);
    chk("same_cycle_wready", wphase_ready_mgr_o, 2'b10);
    tick();
    awphase_valid_mgr_i = '0; wphase_valid_mgr_i = '0;
    awphase_ready_i = 1'b0; wphase_ready_i = 1'b0;
    #1;
    chk("same_cycle_idle", aw_grant_o, 2'b00);

    // wlast before AW ready (AW ready delayed 3 cycles).
    awphase_valid_mgr_i = 2'b01;
    tick();
    chk("early_w_grant", aw_grant_o, 2'b01);
    wphase_valid_mgr_i = 2'b01; wphase_ready_i = 1'b1;
    wphase_mgr_i[0 +: WL] = {49'h3000, 1'b1};
    tick();
    wphase_valid_mgr_i = '0; wphase_ready_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("early_w_hold[%0d]", c), aw_grant_o, 2'b01);
      chk($sformatf("early_w_awvalid[%0d]", c), awphase_valid_o, 1'b1);
      tick();
    end
    awphase_ready_i = 1'b1; awphase_valid_mgr_i = 2'b11;
    #1;
    chk("early_w_awready", awphase_ready_mgr_o, 2'b01);
    tick();
    awphase_valid_mgr_i = 2'b10; awphase_ready_i = 1'b0;
    #1;
    chk("early_w_idle", aw_grant_o, 2'b00);
    tick();
    chk("early_w_next_mgr1", aw_grant_o, 2'b10);
    awphase_ready_i = 1'b1;
    tick();
    awphase_valid_mgr_i = '0; awphase_ready_i = 1'b0;
    #1;
    chk("w_done_cleared", aw_grant_o, 2'b10);
    wphase_valid_mgr_i = 2'b10; wphase_ready_i = 1'b1;
    wphase_mgr_i[WL +: WL] = {49'h4000, 1'b1};
    tick();
    wphase_valid_mgr_i = '0; wphase_ready_i = 1'b0;
    #1;
    chk("mgr1_write_done", aw_grant_o, 2'b00);

    // AR from mgr1 and AW from mgr0 in the same cycle.
    awphase_valid_mgr_i = 2'b01; arphase_valid_mgr_i = 2'b10;
    tick();
    chk("dual_aw_grant", aw_grant_o, 2'b01);
    chk("dual_ar_grant", ar_grant_o, 2'b10);
    chk("dual_ar_data", arphase_o, 100'hB1B1);
    chk("dual_ar_valid", arphase_valid_o, 1'b1);
    arphase_ready_i = 1'b1;
    #1;
    chk("ar_ready_steer", arphase_ready_mgr_o, 2'b10);
    tick();
    arphase_valid_mgr_i = 2'b11; arphase_ready_i = 1'b0;
    #1;
    chk("ar_idle", ar_grant_o, 2'b00);
    tick();
    chk("ar_rr_grant", ar_grant_o, 2'b01);
    chk("ar_rr_data", arphase_o, 100'hB0B0);
    arphase_ready_i = 1'b1;
    tick();
    arphase_valid_mgr_i = '0; arphase_ready_i = 1'b0;

    // Reset mid-burst in W_DATA.
    awphase_ready_i = 1'b1;
    tick();
    awphase_valid_mgr_i = '0; awphase_ready_i = 1'b0;
    wphase_valid_mgr_i = 2'b01; wphase_ready_i = 1'b1;
    wphase_mgr_i[0 +: WL] = {49'h5000, 1'b0};
    tick();
    chk("pre_rst_owner", aw_grant_o, 2'b01);
    rst_i = 1'b1; awphase_ready_i = 1'b1; arphase_ready_i = 1'b1;
    tick();
    chk("mid_rst_aw_grant", aw_grant_o, 2'b00);
    chk("mid_rst_ar_grant", ar_grant_o, 2'b00);
    chk("mid_rst_wvalid", wphase_valid_o, 1'b0);
    chk("mid_rst_wready_mgr", wphase_ready_mgr_o, 2'b00);
    chk("mid_rst_awvalid", awphase_valid_o, 1'b0);
    chk("mid_rst_awready_mgr", awphase_ready_mgr_o, 2'b00);
    chk("mid_rst_arready_mgr", arphase_ready_mgr_o, 2'b00);
    rst_i = 1'b0; wphase_valid_mgr_i = '0; wphase_ready_i = 1'b0;
    awphase_ready_i = 1'b0; arphase_ready_i = 1'b0;
    awphase_valid_mgr_i = 2'b11;
    tick();
    chk("post_rst_grant_mgr0", aw_grant_o, 2'b01);
    awphase_valid_mgr_i = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
